polyphase_mac_sequencer: RTL and testbench

POLYPHASE_MAC_SEQUENCER -- requirements
Module: polyphase_mac_sequencer

---
 rtl/polyphase_mac_sequencer.sv | 166 ++++++++++++++++
 tb/tb_polyphase_mac_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_mac_sequencer.sv
`timescale 1ns/1ps
// Sequencer for a chain of polyphase MAC tiles: loads one coefficient frame into the tiles,
// then streams samples through the chain and presents results on an AXI-Stream output.
module polyphase_mac_sequencer #(
    parameter int unsigned NUM_TAPS          = 8,
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned COEFFICIENT_WIDTH = 16,
    parameter int unsigned CHAIN_LATENCY     = 10
) (
    input  logic                         clock,
    input  logic                         reset,

    input  logic [COEFFICIENT_WIDTH-1:0] s_coeff_tdata,
    input  logic                         s_coeff_tvalid,
    output logic                         s_coeff_tready,
    input  logic                         s_coeff_tlast,

    input  logic [DATA_WIDTH-1:0]        s_data_tdata,
    input  logic                         s_data_tvalid,
    output logic                         s_data_tready,

    input  logic                         reload,

    output logic [COEFFICIENT_WIDTH-1:0] coefficient_out,
    output logic [NUM_TAPS-1:0]          ce_coefficient_out,
    output logic [DATA_WIDTH-1:0]        chain_data_out,
    output logic                         ce_calculate,
    input  logic [DATA_WIDTH-1:0]        chain_result,

    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,

    output logic                         coefficients_loaded,
    output logic                         load_error
);

    localparam int unsigned TapWidth = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [TapWidth-1:0] LastTap = TapWidth'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        StLoad,
        StRun,
        StDrain
    } state_e;

    state_e                         state_q, state_d;
    logic [TapWidth-1:0]            tap_q, tap_d;
    logic [CHAIN_LATENCY-1:0]       valid_q, valid_d;
    logic [COEFFICIENT_WIDTH-1:0]   coeff_q, coeff_d;
    logic [NUM_TAPS-1:0]            ce_coeff_q, ce_coeff_d;
    logic                           loaded_q, loaded_d;
    logic                           error_q, error_d;

    logic                           out_valid;
    logic                           out_free;
    logic                           advance;
    logic                           coeff_beat;
    logic                           last_tap;

    // Bit CHAIN_LATENCY-1 of the valid shift register marks the result at the chain output.
    assign out_valid  = valid_q[CHAIN_LATENCY-1];
    assign out_free   = !out_valid || m_tready;
    assign coeff_beat = s_coeff_tvalid && (state_q == StLoad);
    assign last_tap   = (tap_q == LastTap);

    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            StRun:   advance = s_data_tvalid && out_free;
            StDrain: advance = out_free;
            default: advance = 1'b0;
        endcase
    end

    assign s_coeff_tready      = (state_q == StLoad);
    assign s_data_tready       = (state_q == StRun) && out_free;
    assign ce_calculate        = advance;
    assign chain_data_out      = ((state_q == StRun) && advance) ? s_data_tdata : '0;
    assign m_tvalid            = out_valid;
    assign m_tdata             = out_valid ? chain_result : '0;
    assign coefficient_out     = coeff_q;
    assign ce_coefficient_out  = ce_coeff_q;
    assign coefficients_loaded = loaded_q;
    assign load_error          = error_q;

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        valid_d    = valid_q;
        coeff_d    = coeff_q;
        ce_coeff_d = '0;
        loaded_d   = loaded_q;
        error_d    = error_q;

        // A shift always retires the output slot, so a handshake only needs explicit clearing
        // when the chain is not advancing.
        if (advance) begin
            valid_d = CHAIN_LATENCY'({valid_q, (state_q == StRun)});
        end else if (out_valid && m_tready) begin
            valid_d[CHAIN_LATENCY-1] = 1'b0;
        end

        unique case (state_q)
            StLoad: begin
                if (coeff_beat) begin
                    coeff_d    = s_coeff_tdata;
                    ce_coeff_d = NUM_TAPS'(1) << tap_q;
                    if (last_tap && s_coeff_tlast) begin
                        tap_d    = '0;
                        loaded_d = 1'b1;
                        state_d  = StRun;
                    end else if (last_tap || s_coeff_tlast) begin
                        tap_d   = '0;
                        error_d = 1'b1;
                    end else begin
                        tap_d = tap_q + TapWidth'(1);
                    end
                end
                // A restart request discards any frame in progress, including one just closed.
                if (reload) begin
                    tap_d    = '0;
                    error_d  = 1'b0;
                    loaded_d = loaded_q;
                    state_d  = StLoad;
                end
            end
            StRun: begin
                if (reload) begin
                    state_d  = StDrain;
                    loaded_d = 1'b0;
                    error_d  = 1'b0;
                end
            end
            StDrain: begin
                if (valid_q == '0) begin
                    state_d = StLoad;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StLoad;
            tap_q      <= '0;
            valid_q    <= '0;
            coeff_q    <= '0;
            ce_coeff_q <= '0;
            loaded_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            valid_q    <= valid_d;
            coeff_q    <= coeff_d;
            ce_coeff_q <= ce_coeff_d;
            loaded_q   <= loaded_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_polyphase_mac_sequencer.sv
`timescale 1ns/1ps
// Bench for polyphase_mac_sequencer: the MAC chain is modelled as a delay line advancing on
// ce_calculate, and every accepted sample is scoreboarded against the output stream.
module tb_polyphase_mac_sequencer;

    localparam int unsigned NT = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned CL = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] s_coeff_tdata;
    logic          s_coeff_tvalid;
    logic          s_coeff_tready;
    logic          s_coeff_tlast;
    logic [DW-1:0] s_data_tdata;
    logic          s_data_tvalid;
    logic          s_data_tready;
    logic          reload;
    logic [CW-1:0] coefficient_out;
    logic [NT-1:0] ce_coefficient_out;
    logic [DW-1:0] chain_data_out;
    logic          ce_calculate;
    logic [DW-1:0] chain_result;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          coefficients_loaded;
    logic          load_error;

    int            n_cmp   = 0;
    int            n_err   = 0;
    int            ce_cnt  = 0;
    int            out_cnt = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_d;
    logic [DW-1:0] chain_pipe [CL];
    int            k_m;
    bit            loaded_m;
    bit            err_m;
    bit            rand_ready;

    polyphase_mac_sequencer #(
        .NUM_TAPS          (NT),
        .DATA_WIDTH        (DW),
        .COEFFICIENT_WIDTH (CW),
        .CHAIN_LATENCY     (CL)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .s_coeff_tdata       (s_coeff_tdata),
        .s_coeff_tvalid      (s_coeff_tvalid),
        .s_coeff_tready      (s_coeff_tready),
        .s_coeff_tlast       (s_coeff_tlast),
        .s_data_tdata        (s_data_tdata),
        .s_data_tvalid       (s_data_tvalid),
        .s_data_tready       (s_data_tready),
        .reload              (reload),
        .coefficient_out     (coefficient_out),
        .ce_coefficient_out  (ce_coefficient_out),
        .chain_data_out      (chain_data_out),
        .ce_calculate        (ce_calculate),
        .chain_result        (chain_result),
        .m_tdata             (m_tdata),
        .m_tvalid            (m_tvalid),
        .m_tready            (m_tready),
        .coefficients_loaded (coefficients_loaded),
        .load_error          (load_error)
    );

    always #5 clock = ~clock;

    // Delay-line stand-in for the tile chain.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CL; i++) chain_pipe[i] <= '0;
        end else if (ce_calculate) begin
            for (int i = CL - 1; i > 0; i--) chain_pipe[i] <= chain_pipe[i-1];
            chain_pipe[0] <= chain_data_out;
        end
    end
    assign chain_result = chain_pipe[CL-1];

    // Scoreboard: inputs and outputs are stable at the falling edge.
    always @(negedge clock) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (ce_calculate) ce_cnt++;
            if (m_tvalid && !m_tready) begin
                n_cmp++;
                if (ce_calculate !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_advance: ce_calculate=%b want 0 while output stalled",
                             ce_calculate);
                end
            end
            if (s_data_tvalid && s_data_tready) begin
                n_cmp++;
                if (ce_calculate !== 1'b1 || chain_data_out !== s_data_tdata) begin
                    n_err++;
                    $display("FAIL sample_into_chain: ce=%b data=%h want ce=1 data=%h",
                             ce_calculate, chain_data_out, s_data_tdata);
                end
                sb_q.push_back(s_data_tdata);
            end
            if (m_tvalid && m_tready) begin
                out_cnt++;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL result_order: got result %h want none pending", m_tdata);
                end else begin
                    exp_d = sb_q.pop_front();
                    if (m_tdata !== exp_d) begin
                        n_err++;
                        $display("FAIL result_order: got %h want %h", m_tdata, exp_d);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset          = 1'b1;
        s_coeff_tvalid = 1'b0;
        s_coeff_tlast  = 1'b0;
        s_coeff_tdata  = '0;
        s_data_tvalid  = 1'b0;
        s_data_tdata   = '0;
        reload         = 1'b0;
        m_tready       = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        k_m      = 0;
        loaded_m = 1'b0;
        err_m    = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset(input string tag);
        s_data_tvalid = 1'b1;
        m_tready      = 1'b1;
        #1;
        n_cmp += 9;
        if (coefficient_out !== '0) begin
            n_err++; $display("FAIL %s coefficient_out: got %h want 0", tag, coefficient_out);
        end
        if (ce_coefficient_out !== '0) begin
            n_err++; $display("FAIL %s ce_coefficient_out: got %b want 0", tag, ce_coefficient_out);
        end
        if (ce_calculate !== 1'b0) begin
            n_err++; $display("FAIL %s ce_calculate: got %b want 0", tag, ce_calculate);
        end
        if (m_tvalid !== 1'b0) begin
            n_err++; $display("FAIL %s m_tvalid: got %b want 0", tag, m_tvalid);
        end
        if (m_tdata !== '0) begin
            n_err++; $display("FAIL %s m_tdata: got %h want 0", tag, m_tdata);
        end
        if (coefficients_loaded !== 1'b0) begin
            n_err++; $display("FAIL %s loaded: got %b want 0", tag, coefficients_loaded);
        end
        if (load_error !== 1'b0) begin
            n_err++; $display("FAIL %s load_error: got %b want 0", tag, load_error);
        end
        if (s_data_tready !== 1'b0) begin
            n_err++; $display("FAIL %s s_data_tready: got %b want 0", tag, s_data_tready);
        end
        if (s_coeff_tready !== 1'b1) begin
            n_err++; $display("FAIL %s s_coeff_tready: got %b want 1", tag, s_coeff_tready);
        end
        s_data_tvalid = 1'b0;
    endtask

    // Sends n beats back to back with tlast on beat last_idx (-1 for none).
    task automatic load_frame(input int n, input int last_idx, input logic [CW-1:0] base,
                              input string tag);
        for (int i = 0; i < n; i++) begin
            logic [NT-1:0] exp_ce;
            s_coeff_tvalid = 1'b1;
            s_coeff_tdata  = CW'(base + CW'(i));
            s_coeff_tlast  = (i == last_idx);
            exp_ce = NT'(1) << k_m;
            if (k_m == NT - 1 && i == last_idx) begin
                k_m = 0; loaded_m = 1'b1;
            end else if (k_m == NT - 1 || i == last_idx) begin
                k_m = 0; err_m = 1'b1;
            end else begin
                k_m++;
            end
            @(posedge clock);
            #1;
            n_cmp += 2;
            if (coefficient_out !== CW'(base + CW'(i))) begin
                n_err++;
                $display("FAIL %s coeff beat %0d: got %h want %h", tag, i, coefficient_out,
                         CW'(base + CW'(i)));
            end
            if (ce_coefficient_out !== exp_ce) begin
                n_err++;
                $display("FAIL %s ce_coeff beat %0d: got %b want %b", tag, i, ce_coefficient_out,
                         exp_ce);
            end
        end
        s_coeff_tvalid = 1'b0;
        s_coeff_tlast  = 1'b0;
        @(posedge clock);
        #1;
        n_cmp += 3;
        if (ce_coefficient_out !== '0) begin
            n_err++; $display("FAIL %s ce_coeff idle: got %b want 0", tag, ce_coefficient_out);
        end
        if (coefficients_loaded !== loaded_m) begin
            n_err++;
            $display("FAIL %s loaded: got %b want %b", tag, coefficients_loaded, loaded_m);
        end
        if (load_error !== err_m) begin
            n_err++; $display("FAIL %s load_error: got %b want %b", tag, load_error, err_m);
        end
    endtask

    task automatic send_sample(input logic [DW-1:0] d, output bit ok);
        s_data_tvalid = 1'b1;
        s_data_tdata  = d;
        ok = 1'b0;
        for (int g = 0; g < 100 && !ok; g++) begin
            if (rand_ready) m_tready = 1'($urandom_range(0, 1));
            @(negedge clock);
            ok = s_data_tready;
            @(posedge clock);
            #1;
        end
        s_data_tvalid = 1'b0;
    endtask

    task automatic test_impulse();
        bit ok;
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        ce_cnt     = 0;
        out_cnt    = 0;
        for (int i = 1; i <= 100; i++) begin
            send_sample((i == 1) ? 16'h4000 : 16'h0000, ok);
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL impulse accept %0d: got timeout want accepted", i);
            end
            if (i == 9) begin
                n_cmp++;
                if (m_tvalid !== 1'b0) begin
                    n_err++; $display("FAIL impulse early: m_tvalid=%b want 0", m_tvalid);
                end
            end
            if (i == 10) begin
                n_cmp++;
                if (m_tvalid !== 1'b1 || ce_cnt != 10 || m_tdata !== 16'h4000) begin
                    n_err++;
                    $display("FAIL impulse first: tvalid=%b strobes=%0d data=%h want 1/10/4000",
                             m_tvalid, ce_cnt, m_tdata);
                end
            end
        end
        repeat (5) @(posedge clock);
        #1;
        n_cmp++;
        if (out_cnt != 91 || sb_q.size() != 9) begin
            n_err++;
            $display("FAIL impulse count: got %0d out %0d pending want 91 out 9 pending",
                     out_cnt, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        n_cmp++;
        if (load_error !== 1'b1) begin
            n_err++; $display("FAIL sticky_error: got %b want 1 before reload", load_error);
        end
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            send_sample(DW'($urandom), ok);
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL backpressure accept %0d: got timeout want accepted", i);
            end
        end
        // A sample presented together with reload is still taken when the chain can advance.
        rand_ready    = 1'b0;
        m_tready      = 1'b1;
        s_data_tvalid = 1'b1;
        s_data_tdata  = 16'hBEEF;
        reload        = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (s_data_tready !== 1'b1) begin
            n_err++; $display("FAIL reload_with_sample: tready=%b want 1", s_data_tready);
        end
        @(posedge clock);
        #1;
        reload       = 1'b0;
        s_data_tdata = 16'hDEAD;
        @(negedge clock);
        n_cmp++;
        if (s_data_tready !== 1'b0 || chain_data_out !== '0) begin
            n_err++;
            $display("FAIL drain_blocks_input: tready=%b data=%h want 0/0000", s_data_tready,
                     chain_data_out);
        end
        @(posedge clock);
        #1;
        s_data_tvalid = 1'b0;
        rand_ready    = 1'b1;
        for (int c = 0; c < 300 && !s_coeff_tready; c++) begin
            m_tready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        loaded_m   = 1'b0;
        err_m      = 1'b0;
        k_m        = 0;
        n_cmp++;
        if (s_coeff_tready !== 1'b1 || sb_q.size() != 0 || load_error !== 1'b0 ||
            coefficients_loaded !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure drain: cready=%b pending=%0d err=%b loaded=%b want 1/0/0/0",
                     s_coeff_tready, sb_q.size(), load_error, coefficients_loaded);
        end
    endtask

    task automatic test_reload_drain();
        bit ok;
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_sample(DW'(16'h0100 + i), ok);
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL reload accept %0d: got timeout want accepted", i);
            end
        end
        out_cnt       = 0;
        reload        = 1'b1;
        @(posedge clock);
        #1;
        reload        = 1'b0;
        s_data_tvalid = 1'b1;
        s_data_tdata  = 16'h7777;
        for (int c = 0; c < 100 && !s_coeff_tready; c++) begin
            @(negedge clock);
            n_cmp++;
            if (s_data_tready !== 1'b0) begin
                n_err++; $display("FAIL drain s_data_tready: got %b want 0", s_data_tready);
            end
            @(posedge clock);
            #1;
        end
        s_data_tvalid = 1'b0;
        loaded_m      = 1'b0;
        k_m           = 0;
        n_cmp++;
        if (s_coeff_tready !== 1'b1 || out_cnt != 10 || sb_q.size() != 0 ||
            coefficients_loaded !== 1'b0) begin
            n_err++;
            $display("FAIL reload drain: cready=%b results=%0d pending=%0d loaded=%b want 1/10/0/0",
                     s_coeff_tready, out_cnt, sb_q.size(), coefficients_loaded);
        end
    endtask

    task automatic test_reset_midframe();
        load_frame(2, -1, 16'h0050, "partial");
        do_reset();
        test_reset("midframe");
        load_frame(4, 3, 16'h0A00, "after_reset");
    endtask

    initial begin
        rand_ready = 1'b0;
        do_reset();
        test_reset("por");
        load_frame(3, 2, 16'h00F0, "short_frame");
        load_frame(4, 3, 16'h0001, "good_frame");
        test_impulse();
        test_backpressure();
        load_frame(4, 3, 16'h0010, "reload_frame");
        test_reload_drain();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
